cic_interpolator: RTL and testbench

- Multi-stage CIC interpolator directly downstream of FIR_filter (the CIC droop compensator) in the DAC interpolation chain.
- Accepts one compensated sample every RATE clocks, zero-stuffs, and integrates to the full modulator clock rate.
- Drives the sigma-delta modulator input.
- Generates the low-rate enable strobe that paces FIR_filter.

---
 rtl/cic_pkg.sv | 46 ++++
 rtl/cic_integrator_stage.sv | 21 ++
 rtl/cic_interpolator.sv | 117 +++++++++++
 tb/tb_cic_interpolator.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared helpers for the CIC interpolator: width math and output saturation.
// Everything here is constant-evaluated at elaboration except sat_to_width.
package cic_pkg;

    localparam int SATW = 128;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int acc_width(
        input int bw,
        input int stages,
        input int rate
    );
        return bw + stages * clog2(rate);
    endfunction

    function automatic int shift_amt(
        input int stages,
        input int rate
    );
        return (stages - 1) * clog2(rate);
    endfunction

    function automatic logic signed [SATW-1:0] sat_to_width(
        input logic signed [SATW-1:0] v,
        input int                     bw
    );
        logic signed [SATW-1:0] hi;
        logic signed [SATW-1:0] lo;
        logic signed [SATW-1:0] r;
        hi = signed'((SATW'(1) << (bw - 1)) - SATW'(1));
        lo = ~hi;
        r  = v;
        if (v > hi) r = hi;
        if (v < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One high-rate CIC integrator: wrapping accumulator, frozen when ena is low.
// Wraparound is intentional; the cascade result is exact modulo 2^W.
module cic_integrator_stage
    import cic_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] acc
);

    // accumulate the stage input every enabled clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc <= '0;
        else if (ena) acc <= acc + x;
    end

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: low-rate comb chain, zero-stuffing, high-rate integrators.
// Also produces the sample strobe that paces the upstream FIR stage.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int RATE     = 64,
    parameter int STAGES   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic signed [BITWIDTH-1:0] in,
    output logic                       in_strobe,
    output logic signed [BITWIDTH-1:0] out,
    output logic                       out_valid
);

    localparam int LOG2R = clog2(RATE);
    localparam int ACCW  = acc_width(BITWIDTH, STAGES, RATE);
    localparam int SHIFT = shift_amt(STAGES, RATE);

    logic        [LOG2R-1:0] phase;
    logic                    strobe_d;
    logic signed [ACCW-1:0]  prev [STAGES];
    logic signed [ACCW-1:0]  cin  [STAGES];
    logic signed [ACCW-1:0]  comb_res;
    logic signed [ACCW-1:0]  stuff_reg;
    logic signed [ACCW-1:0]  stuffed;
    logic signed [ACCW-1:0]  integ [STAGES];
    logic signed [ACCW-1:0]  scaled;
    logic signed [SATW-1:0]  wide;
    logic signed [SATW-1:0]  sat;
    logic                    sat_unused;
    logic        [STAGES:0]  vld_sr;

    // phase counter; RATE is a power of two so it wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) phase <= '0;
        else if (ena) phase <= phase + 1'b1;
    end

    assign in_strobe = rst & ena & (phase == '0);

    // cascaded first differences on the sign-extended input
    always_comb begin : comb_chain
        logic signed [ACCW-1:0] d;
        d = {{(ACCW-BITWIDTH){in[BITWIDTH-1]}}, in};
        for (int k = 0; k < STAGES; k++) begin
            cin[k] = d;
            d      = d - prev[k];
        end
        comb_res = d;
    end

    // comb delay registers and stuffed value advance only on strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) prev[k] <= '0;
            stuff_reg <= '0;
        end else if (in_strobe) begin
            for (int k = 0; k < STAGES; k++) prev[k] <= cin[k];
            stuff_reg <= comb_res;
        end
    end

    // remembers that the previous enabled cycle captured a sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) strobe_d <= 1'b0;
        else if (ena) strobe_d <= in_strobe;
    end

    assign stuffed = strobe_d ? stuff_reg : '0;

    for (genvar g = 0; g < STAGES; g++) begin : g_int
        logic signed [ACCW-1:0] x;
        if (g == 0) begin : g_first
            assign x = stuffed;
        end else begin : g_next
            assign x = integ[g-1];
        end
        cic_integrator_stage #(
            .W (ACCW)
        ) u_int (
            .clk (clk),
            .rst (rst),
            .ena (ena),
            .x   (x),
            .acc (integ[g])
        );
    end

    assign scaled = integ[STAGES-1] >>> SHIFT;
    assign wide   = {{(SATW-ACCW){scaled[ACCW-1]}}, scaled};
    assign sat    = sat_to_width(wide, BITWIDTH);
    assign sat_unused = ^sat[SATW-1:BITWIDTH];

    // gain-normalised, saturated output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) out <= '0;
        else if (ena) out <= sat[BITWIDTH-1:0];
    end

    // tracks the first capture through the STAGES+1 cycle latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_sr <= '0;
        else if (ena)
            vld_sr <= {vld_sr[STAGES-1:0], vld_sr[0] | in_strobe};
    end

    // sticky valid once the first sample reaches out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) out_valid <= 1'b0;
        else if (ena && vld_sr[STAGES]) out_valid <= 1'b1;
    end

endmodule

// File: tb/tb_cic_interpolator.sv
// Scoreboard bench: expected outputs are built by convolving captured
// samples with the boxcar^STAGES impulse response, queued per enabled cycle.
module tb_cic_interpolator;

    logic               clk = 1'b0;
    logic               rst;
    logic               ena;
    logic signed [31:0] din;

    logic               s1, s3, s64;
    logic               v1, v3, v64;
    logic signed [31:0] o1, o3, o64;

    logic               obs_s;
    logic               obs_v;
    logic signed [31:0] obs_o;

    int     sel;
    int     S, R, SH;
    longint h[$];
    longint q[$];
    int     phase_m;
    int     since_first;
    longint last_exp;
    int     strobes;
    int     n_tests = 0;
    int     n_fail  = 0;

    always #5 clk = ~clk;

    cic_interpolator #(
        .BITWIDTH (32), .RATE (4), .STAGES (1)
    ) u1 (
        .clk (clk), .rst (rst), .ena (ena), .in (din),
        .in_strobe (s1), .out (o1), .out_valid (v1)
    );

    cic_interpolator #(
        .BITWIDTH (32), .RATE (8), .STAGES (3)
    ) u3 (
        .clk (clk), .rst (rst), .ena (ena), .in (din),
        .in_strobe (s3), .out (o3), .out_valid (v3)
    );

    cic_interpolator #(
        .BITWIDTH (32), .RATE (64), .STAGES (3)
    ) u64 (
        .clk (clk), .rst (rst), .ena (ena), .in (din),
        .in_strobe (s64), .out (o64), .out_valid (v64)
    );

    assign obs_s = (sel == 0) ? s1 : (sel == 1) ? s3 : s64;
    assign obs_v = (sel == 0) ? v1 : (sel == 1) ? v3 : v64;
    assign obs_o = (sel == 0) ? o1 : (sel == 1) ? o3 : o64;

    task automatic chk(
        input string  tag,
        input longint got,
        input longint exp
    );
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat32(input longint v);
        longint r;
        r = v;
        if (v > 64'sd2147483647) r = 64'sd2147483647;
        if (v < -64'sd2147483648) r = -64'sd2147483648;
        return r;
    endfunction

    task automatic build_model(input int s, input int r);
        longint t[$];
        longint acc;
        S  = s;
        R  = r;
        SH = (s - 1) * $clog2(r);
        h.delete();
        repeat (r) h.push_back(64'sd1);
        for (int k = 1; k < s; k++) begin
            t.delete();
            for (int n = 0; n < h.size() + r - 1; n++) begin
                acc = 0;
                for (int j = 0; j < r; j++) begin
                    if (n - j >= 0 && n - j < h.size())
                        acc = acc + h[n-j];
                end
                t.push_back(acc);
            end
            h = t;
        end
    endtask

    task automatic model_reset();
        q.delete();
        phase_m     = 0;
        since_first = -1;
        last_exp    = 0;
        strobes     = 0;
    endtask

    task automatic step();
        bit     se;
        longint x;
        longint e;
        #1;
        se = ena && rst && (phase_m == 0);
        chk("in_strobe", longint'(obs_s), longint'(se));
        if (obs_s) strobes++;
        if (se) begin
            x = longint'(din);
            while (q.size() < S + 1 + h.size()) q.push_back(0);
            for (int m = 0; m < h.size(); m++)
                q[S+1+m] = q[S+1+m] + x * h[m];
            if (since_first < 0) since_first = 0;
        end
        @(posedge clk);
        #1;
        if (ena) begin
            e = (q.size() > 0) ? q.pop_front() : 64'sd0;
            last_exp = sat32(e >>> SH);
            phase_m  = (phase_m + 1) % R;
            if (since_first >= 0) since_first++;
        end
        chk("out", longint'(obs_o), last_exp);
        chk("out_valid", longint'(obs_v),
            longint'(since_first >= S + 2));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", longint'(obs_o), 0);
        chk("rst_valid", longint'(obs_v), 0);
        chk("rst_strobe", longint'(obs_s), 0);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        rst = 1'b0;
        ena = 1'b1;
        din = '0;
        sel = 0;
        build_model(1, 4);
        model_reset();

        // zero-order hold, STAGES=1 RATE=4
        do_reset();
        din = 32'sd7;
        step();
        din = 32'sd0;
        run(14);
        chk("zoh_strobes", strobes, 4);

        // DC settling, STAGES=3 RATE=8
        sel = 1;
        build_model(3, 8);
        do_reset();
        din = 32'sd1000;
        run(40);
        chk("dc_settle", longint'(obs_o), 1000);

        // enable gating during a transient
        din = -32'sd500;
        run(11);
        ena = 1'b0;
        run(5);
        ena = 1'b1;
        run(50);
        chk("dc_neg", longint'(obs_o), -500);

        // full-scale steps
        din = 32'sh7FFF_FFFF;
        run(50);
        chk("sat_hi", longint'(obs_o), 64'sd2147483647);
        din = 32'sh8000_0000;
        run(50);
        chk("sat_lo", longint'(obs_o), -64'sd2147483648);

        // asynchronous reset in the middle of a ramp
        din = 32'sd1000;
        run(10);
        #3;
        rst = 1'b0;
        #1;
        chk("async_out", longint'(obs_o), 0);
        chk("async_valid", longint'(obs_v), 0);
        chk("async_strobe", longint'(obs_s), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        run(40);
        chk("dc_again", longint'(obs_o), 1000);

        // strobe cadence, RATE=64
        sel = 2;
        build_model(3, 64);
        do_reset();
        din = 32'sd12345;
        run(1000);
        chk("strobe_count", strobes, 16);
        chk("dc64", longint'(obs_o), 12345);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
